alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU instance (4-bit op code, operand_A/operand_B, result plus zero flag) between NUM_REQ requesters, e.g. the integer pipe, address generator, and debug/test port.
- Arbitrates round-robin and registers the winning request into an issue stage that drives the ALU.
- Captures the ALU result into a response stage with valid/ready back-pressure.
- Two-stage pipeline: sustains one operation per cycle and tags each response with the requester id.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the shared ALU instance.
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of the requester id; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_op  input  4*NUM_REQ  per-requester ALU op code; requester i uses bits [4i+3:4i].
- req_a  input  DATA_WIDTH*NUM_REQ  per-requester operand A, same slicing.
- req_b  input  DATA_WIDTH*NUM_REQ  per-requester operand B, same slicing.
- req_ready  output  NUM_REQ  one-hot-or-zero grant; a request transfers when req_valid[i] & req_ready[i].
- alu_op  output  4  to the shared ALU's op input.
- alu_a  output  DATA_WIDTH  to the shared ALU's operand_A.
- alu_b  output  DATA_WIDTH  to the shared ALU's operand_B.
- alu_result  input  DATA_WIDTH  from the shared ALU result.
- alu_zero  input  1  from the shared ALU zero flag.
- resp_valid  output  1  response valid.
- resp_ready  input  1  consumer accepts the response.
- resp_result  output  DATA_WIDTH  captured ALU result.
- resp_zero  output  1  captured zero flag.
- resp_id  output  ID_WIDTH  index of the requester that issued the operation.

Behaviour:
- State:
  - S1 issue register: s1_valid, op, a, b, id.
  - S2 response register: s2_valid, result, zero, id.
  - Round-robin pointer last_grant (ID_WIDTH bits).
- Reset (synchronous, wins over everything):
  - s1_valid=0, s2_valid=0, last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - resp_result=0, resp_zero=0, resp_id=0, req_ready=0.
  - Any in-flight operation is discarded with no response.
- Stall and advance:
  - stall = s2_valid & ~resp_ready.
  - s2_load = s1_valid & ~stall.
  - s1_free = ~s1_valid | ~stall.
- Grant logic (combinational):
  - When s1_free, scan requesters starting at last_grant+1 (mod NUM_REQ).
  - Assert req_ready only for the first i with req_valid[i]=1.
  - When not s1_free, req_ready=0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- On a grant edge:
  - S1 loads the winner's op/a/b and id=i; s1_valid=1; last_grant=i.
  - last_grant changes only on a grant.
- When S1 empties with no grant: s1_valid=0.
- When s1_valid & stall: S1 holds all fields unchanged.
- ALU drive:
  - alu_op/alu_a/alu_b = S1 fields when s1_valid.
  - When idle they are forced to 0/0/0 (no toggling).
- S2 update:
  - On s2_load, S2 captures alu_result, alu_zero and S1 id; s2_valid=1.
  - Otherwise, when resp_ready & s2_valid, s2_valid=0 and data fields hold.
  - While stalled, S2 holds all fields.
- Outputs: resp_valid=s2_valid; resp_result/resp_zero/resp_id come directly from S2 (registered outputs).
- Latency: request accepted at edge E0 → resp_valid high in the cycle after E1 (2 cycles).
- Throughput: 1 op/cycle with resp_ready held high.
- Back-pressure:
  - With resp_ready low, at most 2 operations are in flight (S1+S2); further grants are blocked.
  - Deasserting resp_ready must not lose or duplicate a response.
- Arithmetic: the block never inspects op or data. Width and semantics belong to the ALU, including ops 10–15 returning 0 when the condition holds.

Test Plan:
- Reset, then req_valid=0001, op=0, a=5, b=7, resp_ready=1 → req_ready=0001 that cycle; resp_valid 2 cycles later with result=12, zero=0, id=0.
- All four requesters valid continuously with op=8, a=i+10, b=10, resp_ready=1 → grants 0,1,2,3,0… one per cycle; responses in the same order with result=i and zero=1 for id 0.
- Back-pressure: two ops issued, then resp_ready=0 for 5 cycles → req_ready=0 after S1 fills; resp_valid held with stable data; on release both responses delivered in order with no gap and no duplicate.
- Op 10 with a=b=0xFFFFFFFF from requester 2 → resp_result=0, resp_zero=1, resp_id=2; idle cycles drive alu_op=0, alu_a=0, alu_b=0.
- Reset asserted while S1 and S2 are both valid → next cycle resp_valid=0, req_ready=0. After release, with req_valid=1111, requester 0 is granted first.
- Only requester 3 valid while last_grant=3 → requester 3 still granted (wrap-around), and last_grant remains 3.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between NUM_REQ requesters. A round-robin
//   arbiter registers the winning request into an issue stage (S1) that
//   drives the ALU. The ALU result is then captured into a response stage
//   (S2), which uses valid/ready back-pressure and tags each response with
//   the requester id. With resp_ready held high the block sustains one
//   operation per cycle. Latency is two edges from grant to resp_valid.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot-or-zero)
//   req_op/req_a/req_b    per-requester op/operands, requester i in slice i
//   alu_op/alu_a/alu_b    drive to the shared ALU (zero while S1 is idle)
//   alu_result/alu_zero   return from the shared ALU
//   resp_valid/resp_ready response handshake
//   resp_result/zero/id   registered response payload
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [4*NUM_REQ-1:0]          req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [3:0]                    alu_op,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_zero,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_result,
    output logic                          resp_zero,
    output logic [ID_WIDTH-1:0]           resp_id
);

    typedef struct packed {
        logic [3:0]            op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [ID_WIDTH-1:0]   id;
    } iss_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic [ID_WIDTH-1:0]   id;
    } rsp_t;

    // Unpack the flat request buses into per-requester arrays.
    logic [NUM_REQ-1:0][3:0]            op_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] a_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] b_arr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[4*g +: 4];
        assign a_arr[g]  = req_a[DATA_WIDTH*g +: DATA_WIDTH];
        assign b_arr[g]  = req_b[DATA_WIDTH*g +: DATA_WIDTH];
    end

    iss_t                s1_q, s1_d;
    logic                s1_valid_q, s1_valid_d;
    rsp_t                s2_q, s2_d;
    logic                s2_valid_q, s2_valid_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;

    logic                stall, s2_load, s1_free;
    logic                grant_any, grant;
    logic [ID_WIDTH-1:0] grant_idx, scan_idx;

    assign stall   = s2_valid_q & ~resp_ready;
    assign s2_load = s1_valid_q & ~stall;
    assign s1_free = ~s1_valid_q | ~stall;

    // Round-robin scan: start just after the last winner and wrap. The
    // previous winner is checked last, so it still wins when it is alone.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_WIDTH'((int'(last_grant_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Gated by reset so that no transfer is offered while state is clearing.
    assign grant = ~reset & s1_free & grant_any;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[grant_idx] = 1'b1;
    end

    // Next-state for S1 and the round-robin pointer.
    always_comb begin
        s1_d         = s1_q;
        s1_valid_d   = s1_valid_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            s1_d.op      = op_arr[grant_idx];
            s1_d.a       = a_arr[grant_idx];
            s1_d.b       = b_arr[grant_idx];
            s1_d.id      = grant_idx;
            s1_valid_d   = 1'b1;
            last_grant_d = grant_idx;
        end else if (s1_free) begin
            s1_valid_d = 1'b0;
        end
    end

    // Next-state for S2. On a drain without a refill the payload holds.
    always_comb begin
        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_d.result = alu_result;
            s2_d.zero   = alu_zero;
            s2_d.id     = s1_q.id;
            s2_valid_d  = 1'b1;
        end else if (resp_ready && s2_valid_q) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q         <= '0;
            s1_valid_q   <= 1'b0;
            s2_q         <= '0;
            s2_valid_q   <= 1'b0;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            s1_q         <= s1_d;
            s1_valid_q   <= s1_valid_d;
            s2_q         <= s2_d;
            s2_valid_q   <= s2_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    // The ALU inputs are held at zero while idle so that the shared ALU does not toggle.
    assign alu_op = s1_valid_q ? s1_q.op : 4'd0;
    assign alu_a  = s1_valid_q ? s1_q.a  : '0;
    assign alu_b  = s1_valid_q ? s1_q.b  : '0;

    assign resp_valid  = s2_valid_q;
    assign resp_result = s2_q.result;
    assign resp_zero   = s2_q.zero;
    assign resp_id     = s2_q.id;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [4*NR-1:0]   req_op;
    logic [DW*NR-1:0]  req_a, req_b;
    logic [NR-1:0]     req_ready;
    logic [3:0]        alu_op;
    logic [DW-1:0]     alu_a, alu_b, alu_result;
    logic              alu_zero;
    logic              resp_valid, resp_ready;
    logic [DW-1:0]     resp_result;
    logic              resp_zero;
    logic [IW-1:0]     resp_id;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [DW-1:0] res;
        logic          z;
        logic [IW-1:0] id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_id(resp_id)
    );

    // Environment model of the shared ALU (0 add, 8 sub, 10 "equal" -> 0).
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd8:    alu_result = alu_a - alu_b;
            4'd10:   alu_result = (alu_a == alu_b) ? '0 : 32'd1;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops and compares on every accepted response.
    always @(negedge clock) begin
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got id=%0d result=%0h, expected none", resp_id, resp_result);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_result", resp_result, mon_e.res);
                chk("resp_zero", resp_zero, mon_e.z);
                chk("resp_id", resp_id, mon_e.id);
            end
        end
    end

    task automatic push(input logic [DW-1:0] r, input logic z, input logic [IW-1:0] id);
        exp_t e;
        e.res = r; e.z = z; e.id = id;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op[4*i +: 4]   = op;
        req_a[DW*i +: DW]  = a;
        req_b[DW*i +: DW]  = b;
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clock);
        #1;
        chk("drain_empty", sb.size(), 0);
        next_cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] exp_rr;
        reset      = 1'b1;
        req_valid  = '1;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        next_cyc();
        @(negedge clock);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_resp_zero", resp_zero, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_alu_op", alu_op, 0);
        next_cyc();
        reset     = 1'b0;
        req_valid = '0;

        // Single op, latency
        set_req(0, 4'd0, 32'd5, 32'd7);
        req_valid = 4'b0001;
        @(negedge clock);
        chk("t1_req_ready", req_ready, 4'b0001);
        push(32'd12, 1'b0, 2'd0);
        next_cyc();
        req_valid = '0;
        @(negedge clock);
        chk("t1_valid_e0", resp_valid, 0);
        chk("t1_alu_a", alu_a, 32'd5);
        next_cyc();
        @(negedge clock);
        chk("t1_valid_e1", resp_valid, 1);
        next_cyc();
        @(negedge clock);
        chk("t1_valid_after", resp_valid, 0);
        next_cyc();
        drain();

        // Round robin, full throughput
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 4'd8, DW'(i + 10), 32'd10);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            exp_rr = 4'b0001 << (k % 4);
            chk("t2_rr_grant", req_ready, exp_rr);
            push(DW'(k % 4), (k % 4) == 0, IW'(k % 4));
            next_cyc();
        end
        req_valid = '0;
        drain();

        // Back-pressure
        resp_ready = 1'b0;
        set_req(0, 4'd0, 32'd1, 32'd2);
        set_req(1, 4'd0, 32'd3, 32'd4);
        req_valid = 4'b0001;
        @(negedge clock);
        chk("t3_grant0", req_ready, 4'b0001);
        push(32'd3, 1'b0, 2'd0);
        next_cyc();
        req_valid = 4'b0010;
        @(negedge clock);
        chk("t3_grant1", req_ready, 4'b0010);
        push(32'd7, 1'b0, 2'd1);
        next_cyc();
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t3_blocked", req_ready, 0);
            chk("t3_hold_valid", resp_valid, 1);
            chk("t3_hold_result", resp_result, 32'd3);
            chk("t3_hold_id", resp_id, 0);
            next_cyc();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clock);
        chk("t3_rel_v0", resp_valid, 1);
        next_cyc();
        @(negedge clock);
        chk("t3_rel_v1", resp_valid, 1);
        chk("t3_rel_r1", resp_result, 32'd7);
        next_cyc();
        @(negedge clock);
        chk("t3_no_dup", resp_valid, 0);
        next_cyc();
        drain();

        // Op 10 from requester 2, idle ALU drive
        set_req(2, 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b0100;
        @(negedge clock);
        chk("t4_grant2", req_ready, 4'b0100);
        push(32'd0, 1'b1, 2'd2);
        next_cyc();
        req_valid = '0;
        @(negedge clock);
        chk("t4_alu_op", alu_op, 4'd10);
        chk("t4_alu_a", alu_a, 32'hFFFF_FFFF);
        next_cyc();
        @(negedge clock);
        chk("t4_idle_op", alu_op, 0);
        chk("t4_idle_a", alu_a, 0);
        chk("t4_idle_b", alu_b, 0);
        next_cyc();
        drain();

        // Reset with S1 and S2 both occupied (last_grant is 2 here)
        resp_ready = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 4'd0, DW'(i), 32'd1);
        req_valid = 4'b1111;
        @(negedge clock);
        chk("t5_grant3", req_ready, 4'b1000);
        next_cyc();
        @(negedge clock);
        chk("t5_grant0", req_ready, 4'b0001);
        next_cyc();
        reset = 1'b1;
        @(negedge clock);
        chk("t5_rst_rr", req_ready, 0);
        next_cyc();
        @(negedge clock);
        chk("t5_rst_valid", resp_valid, 0);
        chk("t5_rst_rr2", req_ready, 0);
        chk("t5_rst_result", resp_result, 0);
        next_cyc();
        reset      = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        chk("t5_first_grant", req_ready, 4'b0001);
        push(32'd1, 1'b0, 2'd0);
        next_cyc();
        req_valid = '0;
        drain();

        // Wrap-around with a single requester (last_grant is 0 here)
        req_valid = 4'b1000;
        @(negedge clock);
        chk("t6_grant3a", req_ready, 4'b1000);
        push(32'd4, 1'b0, 2'd3);
        next_cyc();
        @(negedge clock);
        chk("t6_grant3b", req_ready, 4'b1000);
        push(32'd4, 1'b0, 2'd3);
        next_cyc();
        req_valid = 4'b1001;
        @(negedge clock);
        chk("t6_after3", req_ready, 4'b0001);
        push(32'd1, 1'b0, 2'd0);
        next_cyc();
        req_valid = '0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
